// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions: operand-forward encodings and hazard FSM types.
// The execute stage decodes the same FWD_* values on its operand muxes.
package hazard_controller_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int STALL_CNT_W = 32;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } hz_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hazard_controller_fwd_select.sv
// One operand's forward select: M-stage result beats W-stage result, r0 never forwarded.
module fwd_select
  import hazard_controller_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic [REG_W-1:0] wr_reg_m_i,
  input  logic             reg_write_m_i,
  input  logic [REG_W-1:0] wr_reg_w_i,
  input  logic             reg_write_w_i,
  output logic [1:0]       sel_o
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_write_m_i && (wr_reg_m_i != '0) && (wr_reg_m_i == src_i);
  assign hit_w = reg_write_w_i && (wr_reg_w_i != '0) && (wr_reg_w_i == src_i);

  always_comb begin
    sel_o = FWD_RF;
    if (hit_m) begin
      sel_o = FWD_M;
    end else if (hit_w) begin
      sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard unit: operand forwarding, load-use stall, multi-cycle ALU stall,
// branch flush and a saturating stall-cycle counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no multi-cycle op in flight; load-use stalls may fire
// ST_BUSY | multi-cycle op held in E; cnt_q counts remaining stall cycles
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int MC_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_W-1:0]       RsD,
  input  logic [REG_W-1:0]       RtD,
  input  logic [REG_W-1:0]       RcD,
  input  logic [REG_W-1:0]       RsE,
  input  logic [REG_W-1:0]       RtE,
  input  logic [REG_W-1:0]       RcE,
  input  logic [REG_W-1:0]       WriteRegE,
  input  logic [REG_W-1:0]       WriteRegM,
  input  logic [REG_W-1:0]       WriteRegW,
  input  logic                   RegWriteE,
  input  logic                   RegWriteM,
  input  logic                   RegWriteW,
  input  logic                   MemtoRegE,
  input  logic                   MultiCycleE,
  input  logic                   BranchTakenD,
  output logic [1:0]             ForwardAE,
  output logic [1:0]             ForwardBE,
  output logic [1:0]             ForwardCE,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   StallE,
  output logic                   FlushD,
  output logic                   FlushE,
  output logic                   BubbleM,
  output logic [STALL_CNT_W-1:0] StallCount
);

  // First stall cycle is spent in IDLE, so BUSY only covers the remaining ones.
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LATENCY - 2);

  hz_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  logic load_use;
  logic mcs;
  logic lu_stall;

  fwd_select u_fwd_a (
    .src_i         (RsE),
    .wr_reg_m_i    (WriteRegM),
    .reg_write_m_i (RegWriteM),
    .wr_reg_w_i    (WriteRegW),
    .reg_write_w_i (RegWriteW),
    .sel_o         (ForwardAE)
  );

  fwd_select u_fwd_b (
    .src_i         (RtE),
    .wr_reg_m_i    (WriteRegM),
    .reg_write_m_i (RegWriteM),
    .wr_reg_w_i    (WriteRegW),
    .reg_write_w_i (RegWriteW),
    .sel_o         (ForwardBE)
  );

  fwd_select u_fwd_c (
    .src_i         (RcE),
    .wr_reg_m_i    (WriteRegM),
    .reg_write_m_i (RegWriteM),
    .wr_reg_w_i    (WriteRegW),
    .reg_write_w_i (RegWriteW),
    .sel_o         (ForwardCE)
  );

  assign load_use = MemtoRegE && RegWriteE && (WriteRegE != '0) &&
                    ((WriteRegE == RsD) || (WriteRegE == RtD) || (WriteRegE == RcD));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcs      = 1'b0;
    lu_stall = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_IDLE: begin
          if (MultiCycleE) begin
            mcs     = 1'b1;
            cnt_d   = MC_LOAD;
            state_d = ST_BUSY;
          end else if (load_use) begin
            lu_stall = 1'b1;
          end
        end
        ST_BUSY: begin
          if (cnt_q != '0) begin
            mcs   = 1'b1;
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign StallF  = mcs | lu_stall;
  assign StallD  = mcs | lu_stall;
  assign StallE  = mcs;
  assign BubbleM = mcs;
  assign FlushE  = lu_stall;
  // A branch under a stall is dropped here; D re-presents it once the stall clears.
  assign FlushD  = BranchTakenD && !StallD && !reset;

  assign stall_count_d = StallD ? sat_inc(stall_count_q) : stall_count_q;
  assign StallCount    = stall_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed plus random checks of hazard_controller against a cycle-level
// model that tracks stall windows as remaining-cycle counts.
module tb_hazard_controller;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  RsD, RtD, RcD, RsE, RtE, RcE;
  logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW;
  logic        MemtoRegE, MultiCycleE, BranchTakenD;
  logic [1:0]  ForwardAE, ForwardBE, ForwardCE;
  logic        StallF, StallD, StallE, FlushD, FlushE, BubbleM;
  logic [31:0] StallCount;

  int compared   = 0;
  int mismatched = 0;

  int          m_stall_left;
  bit          m_release;
  logic [31:0] m_cnt;

  hazard_controller #(.MC_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RcD(RcD),
    .RsE(RsE), .RtE(RtE), .RcE(RcE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MultiCycleE(MultiCycleE), .BranchTakenD(BranchTakenD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardCE(ForwardCE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (RegWriteM && WriteRegM != 0 && WriteRegM == src) return 2'b10;
    if (RegWriteW && WriteRegW != 0 && WriteRegW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_load_use();
    logic [4:0] d_srcs [3];
    d_srcs = '{RsD, RtD, RcD};
    if (!(MemtoRegE && RegWriteE && WriteRegE != 0)) return 1'b0;
    foreach (d_srcs[i]) if (d_srcs[i] == WriteRegE) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_inputs();
    {RsD, RtD, RcD, RsE, RtE, RcE} = '0;
    {WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MultiCycleE, BranchTakenD} = '0;
  endtask

  task automatic rand_inputs();
    RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3)); RcD = 5'($urandom_range(0, 3));
    RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3)); RcE = 5'($urandom_range(0, 3));
    WriteRegE = 5'($urandom_range(0, 3));
    WriteRegM = 5'($urandom_range(0, 3));
    WriteRegW = 5'($urandom_range(0, 3));
    RegWriteE = 1'($urandom_range(0, 1));
    RegWriteM = 1'($urandom_range(0, 1));
    RegWriteW = 1'($urandom_range(0, 1));
    MemtoRegE    = ($urandom % 3) == 0;
    MultiCycleE  = ($urandom % 6) == 0;
    BranchTakenD = ($urandom % 3) == 0;
    reset        = ($urandom % 60) == 0;
  endtask

  // Inputs are applied just after a falling edge; check, clock, update model.
  task automatic cycle();
    bit mcs, lu;
    #1;
    mcs = 0;
    lu  = 0;
    if (!reset) begin
      if (m_stall_left > 0) mcs = 1;
      else if (m_release) mcs = 0;
      else if (MultiCycleE) mcs = 1;
      else if (m_load_use()) lu = 1;
    end
    chk("ForwardAE", 32'(ForwardAE), 32'(m_fwd(RsE)));
    chk("ForwardBE", 32'(ForwardBE), 32'(m_fwd(RtE)));
    chk("ForwardCE", 32'(ForwardCE), 32'(m_fwd(RcE)));
    chk("StallF", 32'(StallF), 32'(mcs | lu));
    chk("StallD", 32'(StallD), 32'(mcs | lu));
    chk("StallE", 32'(StallE), 32'(mcs));
    chk("BubbleM", 32'(BubbleM), 32'(mcs));
    chk("FlushE", 32'(FlushE), 32'(lu));
    chk("FlushD", 32'(FlushD), 32'(BranchTakenD && !reset && !(mcs | lu)));
    chk("StallCount", StallCount, m_cnt);
    @(posedge clk);
    if (reset) begin
      m_stall_left = 0;
      m_release    = 0;
      m_cnt        = 0;
    end else begin
      if ((mcs | lu) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (m_stall_left > 0) begin
        m_stall_left--;
        if (m_stall_left == 0) m_release = 1;
      end else if (m_release) begin
        m_release = 0;
      end else if (MultiCycleE) begin
        m_stall_left = L - 2;
        if (m_stall_left == 0) m_release = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  initial begin
    m_stall_left = 0;
    m_release    = 0;
    m_cnt        = 32'hx;
    clear_inputs();
    reset = 1;
    @(negedge clk);

    // Reset: outputs quiet, forwarding still live.
    RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
    MultiCycleE = 1; BranchTakenD = 1; MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5; RsD = 5;
    #1;
    chk("rst_fwd", 32'(ForwardAE), 32'b10);
    chk("rst_stallf", 32'(StallF), 0);
    chk("rst_flushd", 32'(FlushD), 0);
    m_cnt = 0;
    cycle();
    reset = 0;
    clear_inputs();
    #1;
    chk("rst_count", StallCount, 0);
    chk("rst_stalle", 32'(StallE), 0);

    // Forward priority and r0.
    RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
    #1 chk("fwd_m_prio", 32'(ForwardAE), 32'b10);
    RegWriteM = 0;
    #1 chk("fwd_w", 32'(ForwardAE), 32'b01);
    clear_inputs();
    RtE = 0; WriteRegM = 0; RegWriteM = 1;
    #1 chk("fwd_r0", 32'(ForwardBE), 32'b00);
    cycle();

    // Load-use on the C source.
    clear_inputs();
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 7; RcD = 7;
    #1;
    chk("lu_stallf", 32'(StallF), 1);
    chk("lu_flushe", 32'(FlushE), 1);
    cycle();
    clear_inputs();
    #1;
    chk("lu_one_cycle", 32'(StallD), 0);
    chk("lu_count", StallCount, 1);
    cycle();

    // Multi-cycle op from a clean count: L-1 stall cycles, then release.
    do_reset();
    MultiCycleE = 1;
    for (int i = 0; i < L; i++) begin
      #1;
      chk("mc_stalle", 32'(StallE), (i < L - 1) ? 1 : 0);
      chk("mc_bubblem", 32'(BubbleM), (i < L - 1) ? 1 : 0);
      cycle();
      MultiCycleE = 0;
    end
    chk("mc_count", StallCount, L - 1);

    // MCS beats load-use and branch; MultiCycleE held for the whole op.
    clear_inputs();
    MultiCycleE = 1; MemtoRegE = 1; RegWriteE = 1; WriteRegE = 3; RsD = 3; BranchTakenD = 1;
    #1;
    chk("prio_stalle", 32'(StallE), 1);
    chk("prio_flushe", 32'(FlushE), 0);
    chk("prio_flushd", 32'(FlushD), 0);
    for (int i = 0; i < L; i++) cycle();
    MultiCycleE = 0;
    cycle();

    // Reset in the second BUSY cycle aborts the op.
    clear_inputs();
    MultiCycleE = 1;
    cycle();
    cycle();
    reset = 1;
    cycle();
    reset = 0;
    MultiCycleE = 0;
    #1;
    chk("abort_stalle", 32'(StallE), 0);
    chk("abort_stalld", 32'(StallD), 0);
    chk("abort_count", StallCount, 0);
    cycle();

    // Counter saturation.
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1 release dut.stall_count_q;
    m_cnt = 32'hFFFF_FFFE;
    #1 chk("sat_preload", StallCount, 32'hFFFF_FFFE);
    MultiCycleE = 1;
    cycle();
    MultiCycleE = 0;
    cycle();
    cycle();
    #1 chk("sat_hold", StallCount, 32'hFFFF_FFFF);
    cycle();

    // Random traffic.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rand_inputs();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter MC_LATENCY, default 4: total E-stage cycles of a multi-cycle ALU op; legal range 2..16.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 RsD, RtD, RcD  input  5 each  decode-stage source register numbers (A, B, C).
REQ-005 RsE, RtE, RcE  input  5 each  execute-stage source register numbers (A, B, C).
REQ-006 WriteRegE, WriteRegM, WriteRegW  input  5 each  destination register per stage.
REQ-007 RegWriteE, RegWriteM, RegWriteW  input  1 each  register-write enable per stage.
REQ-008 MemtoRegE  input  1  the E-stage instruction is a load.
REQ-009 MultiCycleE  input  1  the E-stage instruction is a multi-cycle ALU op.
REQ-010 BranchTakenD  input  1  a branch resolved taken in D.
REQ-011 ForwardAE, ForwardBE, ForwardCE  output  2 each  operand select: 00 register file, 01 ResultW, 10 ALUOutM.
REQ-012 StallF, StallD, StallE  output  1 each  hold the stage's pipeline register.
REQ-013 FlushD, FlushE, BubbleM  output  1 each  load a bubble into D, E or M.
REQ-014 StallCount  output  32  number of cycles with StallD high since reset.

Function
REQ-015 Forwarding is combinational, per operand X in {A,B,C}: 10 if RegWriteM, WriteRegM!=0 and WriteRegM==X-source E; else 01 if the same holds for W; else 00.
REQ-016 M has priority over W when both match.
REQ-017 Register 0 is never forwarded.
REQ-018 The load-use condition (LU) is MemtoRegE & RegWriteE & WriteRegE!=0 & WriteRegE in {RsD,RtD,RcD}.
REQ-019 While LU holds and the FSM is in IDLE with MultiCycleE low, the block SHALL assert StallF, StallD and FlushE for exactly that cycle.
REQ-020 The FSM SHALL have states IDLE and BUSY and a 4-bit down-counter cnt.
REQ-021 In IDLE with MultiCycleE=1: assert the multi-cycle stall (MCS), load cnt<=MC_LATENCY-2, and go to BUSY.
REQ-022 In BUSY with cnt!=0: assert MCS and decrement cnt.
REQ-023 In BUSY with cnt==0: deassert MCS and go to IDLE, so the op advances.
REQ-024 MCS SHALL drive StallF, StallD, StallE and BubbleM high and FlushE low.
REQ-025 A multi-cycle op SHALL stall for exactly MC_LATENCY-1 cycles.
REQ-026 MCS takes precedence over LU: no FlushE is issued while MCS is asserted.
REQ-027 FlushD = BranchTakenD & ~StallD; a taken branch coincident with any stall is deferred, and the D-stage branch logic re-presents it.
REQ-028 StallCount increments each cycle StallD=1 and saturates at 32'hFFFF_FFFF without wrapping.
REQ-029 Forward*, StallF, StallD, FlushD and FlushE are combinational from the inputs and state; only state, cnt and StallCount are registered.

Reset
REQ-030 Reset SHALL set the state to IDLE, cnt to 0 and StallCount to 0 on the next rising clock edge.
REQ-031 While reset is high, all stall, flush and bubble outputs are 0 and Forward* reflects its inputs.
REQ-032 Reset asserted mid-BUSY aborts the multi-cycle op; the FSM is in IDLE the cycle after reset deasserts.

Structure
REQ-033 A shared pipeline package SHALL hold the Forward encodings (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10) and the FSM state typedef; the execute stage uses the same encodings.
REQ-034 A single sub-module, fwd_select, SHALL compute one 2-bit select and be instantiated three times (A, B, C).
REQ-035 Everything else (FSM, counters) is flat within hazard_controller.

Verification
REQ-036 RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 -> ForwardAE=10; with RegWriteM=0 -> ForwardAE=01.
REQ-037 RtE=0, WriteRegM=0, RegWriteM=1 -> ForwardBE=00.
REQ-038 MemtoRegE=1, RegWriteE=1, WriteRegE=7, RcD=7 -> StallF=StallD=FlushE=1 for 1 cycle and StallCount +1.
REQ-039 MC_LATENCY=4, MultiCycleE pulsed in IDLE -> StallE=BubbleM=1 for 3 consecutive cycles, 0 on the 4th; StallCount=3.
REQ-040 MultiCycleE=1, LU=1 and BranchTakenD=1 in the same cycle -> MCS only: FlushE=0, FlushD=0.
REQ-041 Reset asserted on the 2nd BUSY cycle -> all stalls 0 the next cycle, StallCount=0, state IDLE.
REQ-042 StallCount forced to 32'hFFFF_FFFE, then 3 stall cycles -> StallCount=32'hFFFF_FFFF.
